sliding_window_buffer: RTL and testbench

SLIDING_WINDOW_BUFFER -- requirements
Module: sliding_window_buffer

---
 rtl/sliding_window_buffer.sv | 131 +++++++++++++
 tb/tb_sliding_window_buffer.sv | 381 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sliding_window_buffer.sv
// sliding_window_buffer: builds a KERNEL_SIZE x KERNEL_SIZE window over a raster pixel stream (stride 1, no padding).
// Latency: one cycle; window_out/window_valid/frame_done are registered at the edge that accepts the pixel.
// Backpressure: none; every pixel_valid cycle is consumed, idle cycles freeze counters, storage and window_out.
//
// Ports:
//   clock         sole clock, rising edge
//   reset         synchronous, active-high; clears position, zeroes outputs, ignores pixel_valid
//   pixel_in      raster-order pixel, row-major, top-left first
//   pixel_valid   pixel_in is accepted on this edge
//   window_out    packed window, element l = r*KERNEL_SIZE + c at [DATA_WIDTH*(l+1)-1 : DATA_WIDTH*l],
//                 r=0 oldest row, c=0 oldest column
//   window_valid  window_out holds a new complete window this cycle
//   frame_done    pulses with the last window of the frame
module sliding_window_buffer #(
  parameter int KERNEL_SIZE  = 3,
  parameter int DATA_WIDTH   = 16,
  parameter int IMAGE_WIDTH  = 28,
  parameter int IMAGE_HEIGHT = 28
) (
  input  logic                                          clock,
  input  logic                                          reset,
  input  logic [DATA_WIDTH-1:0]                         pixel_in,
  input  logic                                          pixel_valid,
  output logic [DATA_WIDTH*KERNEL_SIZE*KERNEL_SIZE-1:0] window_out,
  output logic                                          window_valid,
  output logic                                          frame_done
);

  localparam int K  = KERNEL_SIZE;
  localparam int CW = $clog2(IMAGE_WIDTH);
  localparam int RW = $clog2(IMAGE_HEIGHT);

  localparam logic [CW-1:0] COL_LAST = CW'(IMAGE_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMAGE_HEIGHT - 1);
  // First column/row at which a full window exists.
  localparam logic [CW-1:0] COL_FULL = CW'(K - 1);
  localparam logic [RW-1:0] ROW_FULL = RW'(K - 1);

  // Position of the next pixel to be accepted.
  logic [CW-1:0] col;
  logic [RW-1:0] row;

  // line_buf[0] holds the oldest stored row, line_buf[K-2] the row just above the current one.
  logic [DATA_WIDTH-1:0] line_buf [0:K-2][0:IMAGE_WIDTH-1];
  logic [DATA_WIDTH-1:0] win      [0:K-1][0:K-1];

  logic [DATA_WIDTH-1:0] col_vec  [0:K-1];
  logic [DATA_WIDTH-1:0] win_nxt  [0:K-1][0:K-1];
  logic [DATA_WIDTH*K*K-1:0] win_flat;

  logic accept;
  logic emit;
  logic at_last;

  assign accept  = pixel_valid && !reset;
  assign at_last = (col == COL_LAST) && (row == ROW_LAST);
  // Stale line-buffer contents (after reset or from the previous frame) are
  // only ever read in rows below ROW_FULL, which never emit.
  assign emit    = accept && (col >= COL_FULL) && (row >= ROW_FULL);

  // Vertical column entering the window: stored rows above, new pixel at the bottom.
  always_comb begin
    for (int r = 0; r < K - 1; r++) begin
      col_vec[r] = line_buf[r][col];
    end
    col_vec[K-1] = pixel_in;
  end

  // Window after shifting left one column and appending col_vec on the right.
  always_comb begin
    for (int r = 0; r < K; r++) begin
      for (int c = 0; c < K - 1; c++) begin
        win_nxt[r][c] = win[r][c+1];
      end
      win_nxt[r][K-1] = col_vec[r];
    end
  end

  always_comb begin
    win_flat = '0;
    for (int r = 0; r < K; r++) begin
      for (int c = 0; c < K; c++) begin
        win_flat[DATA_WIDTH*(r*K+c) +: DATA_WIDTH] = win_nxt[r][c];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      col <= '0;
      row <= '0;
    end else if (pixel_valid) begin
      if (col == COL_LAST) begin
        col <= '0;
        row <= (row == ROW_LAST) ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  // Storage is deliberately not reset; see the emit qualification above.
  always_ff @(posedge clock) begin
    if (accept) begin
      // Each line buffer slot moves up one row; the new pixel lands in the newest row.
      for (int r = 0; r < K - 1; r++) begin
        line_buf[r][col] <= col_vec[r+1];
      end
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K; c++) begin
          win[r][c] <= win_nxt[r][c];
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      window_out   <= '0;
      window_valid <= 1'b0;
      frame_done   <= 1'b0;
    end else begin
      window_valid <= emit;
      frame_done   <= emit && at_last;
      if (emit) begin
        window_out <= win_flat;
      end
    end
  end

endmodule

// File: tb/tb_sliding_window_buffer.sv
module tb_sliding_window_buffer;

  localparam int K    = 3;
  localparam int DW   = 16;
  localparam int W    = 28;
  localparam int H    = 28;
  localparam int NWIN = (W - K + 1) * (H - K + 1);

  localparam int K5    = 5;
  localparam int W5    = 8;
  localparam int H5    = 8;
  localparam int NWIN5 = (W5 - K5 + 1) * (H5 - K5 + 1);

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic                  reset = 1'b1;
  logic [DW-1:0]         pixel_in = '0;
  logic                  pixel_valid = 1'b0;
  logic [DW*K*K-1:0]     window_out;
  logic                  window_valid;
  logic                  frame_done;

  logic                  reset5 = 1'b1;
  logic [DW-1:0]         pixel_in5 = '0;
  logic                  pixel_valid5 = 1'b0;
  logic [DW*K5*K5-1:0]   window_out5;
  logic                  window_valid5;
  logic                  frame_done5;

  sliding_window_buffer #(
    .KERNEL_SIZE(K), .DATA_WIDTH(DW), .IMAGE_WIDTH(W), .IMAGE_HEIGHT(H)
  ) dut (
    .clock(clock), .reset(reset), .pixel_in(pixel_in), .pixel_valid(pixel_valid),
    .window_out(window_out), .window_valid(window_valid), .frame_done(frame_done)
  );

  sliding_window_buffer #(
    .KERNEL_SIZE(K5), .DATA_WIDTH(DW), .IMAGE_WIDTH(W5), .IMAGE_HEIGHT(H5)
  ) dut5 (
    .clock(clock), .reset(reset5), .pixel_in(pixel_in5), .pixel_valid(pixel_valid5),
    .window_out(window_out5), .window_valid(window_valid5), .frame_done(frame_done5)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: remembers every pixel of the frame in progress by its
  // raster position and cuts the expected window straight out of that image.
  logic [DW-1:0]     img [0:H-1][0:W-1];
  int                m_row;
  int                m_col;
  bit                e_vld;
  bit                e_done;
  bit                e_known;   // window_out value is defined by the rules (emitted, held, or reset zero)
  logic [DW*K*K-1:0] e_win;

  function automatic void model_reset();
    m_row   = 0;
    m_col   = 0;
    e_vld   = 1'b0;
    e_done  = 1'b0;
    e_known = 1'b1;
    e_win   = '0;
  endfunction

  function automatic void model_step(input bit v, input logic [DW-1:0] d);
    e_vld  = 1'b0;
    e_done = 1'b0;
    if (!v) return;
    img[m_row][m_col] = d;
    if (m_row >= K - 1 && m_col >= K - 1) begin
      for (int r = 0; r < K; r++)
        for (int c = 0; c < K; c++)
          e_win[DW*(r*K+c) +: DW] = img[m_row-K+1+r][m_col-K+1+c];
      e_vld   = 1'b1;
      e_done  = (m_row == H - 1) && (m_col == W - 1);
      e_known = 1'b1;
    end else begin
      e_known = 1'b0;
    end
    m_col++;
    if (m_col == W) begin
      m_col = 0;
      m_row++;
      if (m_row == H) m_row = 0;
    end
  endfunction

  function automatic logic [DW*K*K-1:0] first_window(input int base);
    logic [DW*K*K-1:0] w;
    for (int r = 0; r < K; r++)
      for (int c = 0; c < K; c++)
        w[DW*(r*K+c) +: DW] = DW'(base + r*W + c);
    return w;
  endfunction

  task automatic test_reset();
    reset       = 1'b1;
    pixel_valid = 1'b1;
    pixel_in    = 16'hABCD;
    repeat (3) begin
      @(posedge clock); #1;
      n_cmp++;
      if (window_valid !== 1'b0 || frame_done !== 1'b0 || window_out !== '0) begin
        n_bad++;
        $display("FAIL reset_outputs: got vld=%b done=%b win=%h, want 0/0/0", window_valid, frame_done, window_out);
      end
    end
    pixel_valid = 1'b0;
    reset       = 1'b0;
    model_reset();
  endtask

  task automatic test_continuous_frame();
    int nw = 0;
    int nd = 0;
    bit seen_first = 1'b0;
    for (int i = 0; i < W * H; i++) begin
      pixel_valid = 1'b1;
      pixel_in    = DW'(i);
      @(posedge clock); #1;
      model_step(1'b1, DW'(i));
      n_cmp++;
      if (window_valid !== e_vld) begin
        n_bad++; $display("FAIL cont_valid px=%0d: got %b want %b", i, window_valid, e_vld);
      end
      n_cmp++;
      if (frame_done !== e_done) begin
        n_bad++; $display("FAIL cont_done px=%0d: got %b want %b", i, frame_done, e_done);
      end
      if (e_known) begin
        n_cmp++;
        if (window_out !== e_win) begin
          n_bad++; $display("FAIL cont_window px=%0d: got %h want %h", i, window_out, e_win);
        end
      end
      if (i % W < K - 1) begin
        n_cmp++;
        if (window_valid !== 1'b0) begin
          n_bad++; $display("FAIL cont_left_cols px=%0d: got vld %b want 0", i, window_valid);
        end
      end
      if (window_valid === 1'b1 && !seen_first) begin
        seen_first = 1'b1;
        n_cmp++;
        if (i != 58) begin
          n_bad++; $display("FAIL first_window_latency: got after px %0d want after px 58", i);
        end
        n_cmp++;
        if (window_out !== first_window(0)) begin
          n_bad++; $display("FAIL first_window: got %h want %h", window_out, first_window(0));
        end
      end
      if (i == 86) begin
        n_cmp++;
        if (window_valid !== 1'b1 || window_out !== first_window(28)) begin
          n_bad++; $display("FAIL window_px86: got vld=%b %h want 1 %h", window_valid, window_out, first_window(28));
        end
      end
      if (window_valid === 1'b1) nw++;
      if (frame_done === 1'b1) nd++;
    end
    pixel_valid = 1'b0;
    n_cmp++;
    if (nw != NWIN) begin
      n_bad++; $display("FAIL cont_window_count: got %0d want %0d", nw, NWIN);
    end
    n_cmp++;
    if (nd != 1) begin
      n_bad++; $display("FAIL cont_frame_done_count: got %0d want 1", nd);
    end
  endtask

  task automatic test_gaps();
    int nw = 0;
    int nd = 0;
    int i = 0;
    int cyc = 0;
    bit v;
    while (i < W * H && cyc < 8 * W * H) begin
      v           = 1'($urandom_range(0, 1));
      pixel_valid = v;
      pixel_in    = v ? DW'(i) : DW'($urandom);
      @(posedge clock); #1;
      model_step(v, pixel_in);
      cyc++;
      n_cmp++;
      if (window_valid !== e_vld) begin
        n_bad++; $display("FAIL gap_valid cyc=%0d: got %b want %b", cyc, window_valid, e_vld);
      end
      n_cmp++;
      if (frame_done !== e_done) begin
        n_bad++; $display("FAIL gap_done cyc=%0d: got %b want %b", cyc, frame_done, e_done);
      end
      if (e_known) begin
        n_cmp++;
        if (window_out !== e_win) begin
          n_bad++; $display("FAIL gap_window cyc=%0d (valid_in=%b): got %h want %h", cyc, v, window_out, e_win);
        end
      end
      if (window_valid === 1'b1) nw++;
      if (frame_done === 1'b1) nd++;
      if (v) i++;
    end
    pixel_valid = 1'b0;
    n_cmp++;
    if (i != W * H) begin
      n_bad++; $display("FAIL gap_budget: got %0d pixels want %0d", i, W * H);
    end
    n_cmp++;
    if (nw != NWIN || nd != 1) begin
      n_bad++; $display("FAIL gap_counts: got %0d windows %0d done want %0d and 1", nw, nd, NWIN);
    end
  endtask

  task automatic test_back_to_back();
    int nw = 0;
    int nd [2] = '{0, 0};
    bit seen2 = 1'b0;
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < W * H; i++) begin
        pixel_valid = 1'b1;
        pixel_in    = DW'(f * 1000 + i);
        @(posedge clock); #1;
        model_step(1'b1, pixel_in);
        n_cmp++;
        if (window_valid !== e_vld || frame_done !== e_done) begin
          n_bad++; $display("FAIL b2b_flags f=%0d px=%0d: got %b/%b want %b/%b", f, i, window_valid, frame_done, e_vld, e_done);
        end
        if (e_known) begin
          n_cmp++;
          if (window_out !== e_win) begin
            n_bad++; $display("FAIL b2b_window f=%0d px=%0d: got %h want %h", f, i, window_out, e_win);
          end
        end
        if (frame_done === 1'b1) begin
          nd[f]++;
          n_cmp++;
          if (f == 0 && window_out[DW*(K*K-1) +: DW] !== DW'(783)) begin
            n_bad++; $display("FAIL b2b_last_elem: got %0d want 783", window_out[DW*(K*K-1) +: DW]);
          end
        end
        if (f == 1 && window_valid === 1'b1 && !seen2) begin
          seen2 = 1'b1;
          n_cmp++;
          if (window_out !== first_window(1000)) begin
            n_bad++; $display("FAIL b2b_first_f2: got %h want %h", window_out, first_window(1000));
          end
        end
        if (window_valid === 1'b1) nw++;
      end
    end
    pixel_valid = 1'b0;
    n_cmp++;
    if (nd[0] != 1 || nd[1] != 1 || nw != 2 * NWIN) begin
      n_bad++; $display("FAIL b2b_counts: got done %0d/%0d windows %0d want 1/1 %0d", nd[0], nd[1], nw, 2 * NWIN);
    end
  endtask

  task automatic test_mid_reset();
    int nw = 0;
    int first_px = -1;
    for (int i = 0; i < 300; i++) begin
      pixel_valid = 1'b1;
      pixel_in    = DW'($urandom);
      @(posedge clock); #1;
      model_step(1'b1, pixel_in);
      n_cmp++;
      if (window_valid !== e_vld || (e_known && window_out !== e_win)) begin
        n_bad++; $display("FAIL pre_reset px=%0d: got %b %h want %b %h", i, window_valid, window_out, e_vld, e_win);
      end
    end
    reset       = 1'b1;
    pixel_valid = 1'b1;
    pixel_in    = DW'($urandom);
    @(posedge clock); #1;
    n_cmp++;
    if (window_valid !== 1'b0 || frame_done !== 1'b0 || window_out !== '0) begin
      n_bad++; $display("FAIL mid_reset_outputs: got %b/%b %h want 0/0 zero", window_valid, frame_done, window_out);
    end
    reset = 1'b0;
    model_reset();
    for (int i = 0; i < W * H; i++) begin
      pixel_valid = 1'b1;
      pixel_in    = DW'(i);
      @(posedge clock); #1;
      model_step(1'b1, DW'(i));
      n_cmp++;
      if (window_valid !== e_vld || frame_done !== e_done) begin
        n_bad++; $display("FAIL post_reset_flags px=%0d: got %b/%b want %b/%b", i, window_valid, frame_done, e_vld, e_done);
      end
      if (e_known) begin
        n_cmp++;
        if (window_out !== e_win) begin
          n_bad++; $display("FAIL post_reset_window px=%0d: got %h want %h", i, window_out, e_win);
        end
      end
      if (window_valid === 1'b1) begin
        nw++;
        if (first_px < 0) first_px = i;
      end
    end
    pixel_valid = 1'b0;
    n_cmp++;
    if (nw != NWIN || first_px != 58) begin
      n_bad++; $display("FAIL post_reset_counts: got %0d windows first after px %0d want %0d after 58", nw, first_px, NWIN);
    end
  endtask

  task automatic test_k5();
    int nw = 0;
    int nd = 0;
    int i = 0;
    int cyc = 0;
    bit v;
    bit ev;
    bit seen_first = 1'b0;
    logic [DW*K5*K5-1:0] ew;
    logic [DW*K5*K5-1:0] first5;
    for (int r = 0; r < K5; r++)
      for (int c = 0; c < K5; c++)
        first5[DW*(r*K5+c) +: DW] = DW'(r * W5 + c);
    reset5 = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    n_cmp++;
    if (window_valid5 !== 1'b0 || frame_done5 !== 1'b0 || window_out5 !== '0) begin
      n_bad++; $display("FAIL k5_reset: got %b/%b %h want 0/0 zero", window_valid5, frame_done5, window_out5);
    end
    reset5 = 1'b0;
    while (i < W5 * H5 && cyc < 1000) begin
      v            = ($urandom_range(0, 3) != 0);
      pixel_valid5 = v;
      pixel_in5    = DW'(i);
      @(posedge clock); #1;
      cyc++;
      ev = v && (i / W5 >= K5 - 1) && (i % W5 >= K5 - 1);
      n_cmp++;
      if (window_valid5 !== ev || frame_done5 !== (ev && i == W5 * H5 - 1)) begin
        n_bad++; $display("FAIL k5_flags px=%0d: got %b/%b want %b", i, window_valid5, frame_done5, ev);
      end
      if (ev) begin
        for (int r = 0; r < K5; r++)
          for (int c = 0; c < K5; c++)
            ew[DW*(r*K5+c) +: DW] = DW'((i / W5 - K5 + 1 + r) * W5 + (i % W5 - K5 + 1 + c));
        n_cmp++;
        if (window_out5 !== ew) begin
          n_bad++; $display("FAIL k5_window px=%0d: got %h want %h", i, window_out5, ew);
        end
        if (!seen_first) begin
          seen_first = 1'b1;
          n_cmp++;
          if (window_out5 !== first5) begin
            n_bad++; $display("FAIL k5_first_window: got %h want %h", window_out5, first5);
          end
        end
      end
      if (window_valid5 === 1'b1) nw++;
      if (frame_done5 === 1'b1) nd++;
      if (v) i++;
    end
    pixel_valid5 = 1'b0;
    n_cmp++;
    if (nw != NWIN5 || nd != 1 || i != W5 * H5) begin
      n_bad++; $display("FAIL k5_counts: got %0d windows %0d done %0d px want %0d 1 %0d", nw, nd, i, NWIN5, W5 * H5);
    end
  endtask

  initial begin
    test_reset();
    test_continuous_frame();
    test_gaps();
    test_back_to_back();
    test_mid_reset();
    test_k5();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
